// File: rtl/uart_tx_frame_arbiter.sv
// uart_tx_frame_arbiter: round-robin arbiter sequencing 2-byte UART frames from NUM_REQ requesters
module uart_tx_frame_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int GAP_CYCLES     = 16,
   parameter int TIMEOUT_CYCLES = 2000000
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic [NUM_REQ-1:0]         req_i,
   input  logic [8*NUM_REQ-1:0]       req_byte_one_i,
   input  logic [8*NUM_REQ-1:0]       req_byte_two_i,
   output logic [NUM_REQ-1:0]         ack_o,
   output logic                       tx_enable_o,
   output logic [7:0]                 tx_byte_one_o,
   output logic [7:0]                 tx_byte_two_o,
   input  logic                       tx_done_i,
   output logic                       busy_o,
   output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
   output logic                       timeout_err_o
);
   localparam int IW = $clog2(NUM_REQ);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam logic [IW:0]   NR    = (IW+1)'(NUM_REQ);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [GW-1:0] GLAST = GW'(GAP_CYCLES - 1);
   typedef enum logic [2:0] {IDLE, LAUNCH, W1_HI, W1_LO, W2_HI, W2_LO, GAP} state_t;
   state_t              state_q, wnext_d;
   logic [IW-1:0]       ptr_q, ptr_d, gnt_d, grant_q;
   logic [IW:0]         idx_d;
   logic                found_d, tx_enable_q, busy_q, terr_q;
   logic [TW-1:0]       tcnt_q;
   logic [GW-1:0]       gcnt_q;
   logic [NUM_REQ-1:0]  ack_q, onehot_d;
   logic [7:0]          b1_q, b2_q;
   // Pick the first pending request at or above the RR pointer (wrapping) and the wait-state successor
   always_comb begin
      found_d = 1'b0;
      gnt_d = '0;
      idx_d = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx_d = {1'b0, ptr_q} + (IW+1)'(k);
         idx_d = idx_d >= NR ? idx_d - NR : idx_d;
         if (!found_d && req_i[idx_d[IW-1:0]]) begin
            found_d = 1'b1;
            gnt_d = idx_d[IW-1:0];
         end
      end
      ptr_d = ({1'b0, gnt_d} == NR - 1'b1) ? '0 : gnt_d + 1'b1;
      onehot_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;
      wnext_d = state_q == W1_HI ? (tx_done_i ? W1_LO : W1_HI) :
                state_q == W1_LO ? (!tx_done_i ? W2_HI : W1_LO) :
                state_q == W2_HI ? (tx_done_i ? W2_LO : W2_HI) : state_q;
   end
   // Frame sequencer: grant, launch, follow tx_done through both bytes, ack, then enforce the idle gap
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         ptr_q <= '0;
         grant_q <= '0;
         tcnt_q <= '0;
         gcnt_q <= '0;
         ack_q <= '0;
         tx_enable_q <= 1'b0;
         busy_q <= 1'b0;
         terr_q <= 1'b0;
         b1_q <= '0;
         b2_q <= '0;
      end else begin
         ack_q <= '0;
         tx_enable_q <= 1'b0;
         case (state_q)
            IDLE: if (found_d) begin
               state_q <= LAUNCH;
               tx_enable_q <= 1'b1;
               busy_q <= 1'b1;
               grant_q <= gnt_d;
               ptr_q <= ptr_d;
               b1_q <= req_byte_one_i[{gnt_d, 3'b000} +: 8];
               b2_q <= req_byte_two_i[{gnt_d, 3'b000} +: 8];
            end
            LAUNCH: begin
               tcnt_q <= TW'(1);
               state_q <= W1_HI;
            end
            GAP: if (gcnt_q == GLAST) begin
               busy_q <= 1'b0;
               state_q <= IDLE;
            end else gcnt_q <= gcnt_q + 1'b1;
            default: if (state_q == W2_LO && !tx_done_i) begin
               ack_q <= onehot_d;
               terr_q <= 1'b0;
               gcnt_q <= '0;
               state_q <= GAP;
            end else if (tcnt_q == TLAST) begin
               ack_q <= onehot_d;
               terr_q <= 1'b1;
               gcnt_q <= '0;
               state_q <= GAP;
            end else begin
               tcnt_q <= tcnt_q + 1'b1;
               state_q <= wnext_d;
            end
         endcase
      end
   end
   assign ack_o = ack_q;
   assign tx_enable_o = tx_enable_q;
   assign tx_byte_one_o = b1_q;
   assign tx_byte_two_o = b2_q;
   assign busy_o = busy_q;
   assign grant_id_o = grant_q;
   assign timeout_err_o = terr_q;
endmodule

// File: tb/tb_uart_tx_frame_arbiter.sv
// tb_uart_tx_frame_arbiter: scoreboard bench for the round-robin UART frame arbiter
module tb_uart_tx_frame_arbiter;
   localparam int N = 4, GAP = 4, TMO = 100;
   logic clk = 1'b0, reset_i = 1'b1, tx_done_i = 1'b0;
   logic [N-1:0] req_i = '0, ack_o;
   logic [8*N-1:0] req_byte_one_i = '0, req_byte_two_i = '0;
   logic tx_enable_o, busy_o, timeout_err_o;
   logic [7:0] tx_byte_one_o, tx_byte_two_o;
   logic [1:0] grant_id_o;
   int tests = 0, fails = 0;
   typedef struct {logic [1:0] id; logic [7:0] b1; logic [7:0] b2;} launch_t;
   typedef struct {logic [3:0] ack; logic [7:0] b1; logic [7:0] b2; logic terr;} ack_t;
   launch_t lq[$];
   ack_t aq[$];
   launch_t le;
   ack_t ae;

   uart_tx_frame_arbiter #(.NUM_REQ(N), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
      .clk_i(clk), .reset_i(reset_i), .req_i(req_i),
      .req_byte_one_i(req_byte_one_i), .req_byte_two_i(req_byte_two_i),
      .ack_o(ack_o), .tx_enable_o(tx_enable_o), .tx_byte_one_o(tx_byte_one_o),
      .tx_byte_two_o(tx_byte_two_o), .tx_done_i(tx_done_i), .busy_o(busy_o),
      .grant_id_o(grant_id_o), .timeout_err_o(timeout_err_o));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every launch and every ack is matched against the expectation queues
   always @(negedge clk) begin
      if (!reset_i && tx_enable_o) begin
         if (lq.size() == 0) begin
            tests++; fails++;
            $display("FAIL launch_unexpected: got grant %0d expected none", grant_id_o);
         end else begin
            le = lq.pop_front();
            chk("launch_id", 32'(grant_id_o), 32'(le.id));
            chk("launch_b1", 32'(tx_byte_one_o), 32'(le.b1));
            chk("launch_b2", 32'(tx_byte_two_o), 32'(le.b2));
         end
      end
      if (!reset_i && ack_o != '0) begin
         if (aq.size() == 0) begin
            tests++; fails++;
            $display("FAIL ack_unexpected: got %b expected none", ack_o);
         end else begin
            ae = aq.pop_front();
            chk("ack_vec", 32'(ack_o), 32'(ae.ack));
            chk("ack_b1", 32'(tx_byte_one_o), 32'(ae.b1));
            chk("ack_b2", 32'(tx_byte_two_o), 32'(ae.b2));
            chk("ack_terr", 32'(timeout_err_o), 32'(ae.terr));
         end
      end
   end

   task automatic wait_en();
      int n = 0;
      while (!tx_enable_o && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) begin tests++; fails++; $display("FAIL wait_launch: got no tx_enable expected one within 200"); end
   endtask

   task automatic wait_ack();
      int n = 0;
      while (ack_o == '0 && n < 400) begin @(negedge clk); n++; end
      if (n >= 400) begin tests++; fails++; $display("FAIL wait_ack: got no ack expected one within 400"); end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy_o && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) begin tests++; fails++; $display("FAIL wait_idle: got busy expected idle within 100"); end
   endtask

   task automatic drive_done();
      repeat (2) @(negedge clk);
      tx_done_i = 1'b1;
      repeat (3) @(negedge clk);
      tx_done_i = 1'b0;
      repeat (3) @(negedge clk);
      tx_done_i = 1'b1;
      repeat (3) @(negedge clk);
      tx_done_i = 1'b0;
   endtask

   task automatic frame();
      wait_en();
      drive_done();
      wait_ack();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200us");
      $fatal(1);
   end

   initial begin
      int n;
      repeat (3) @(negedge clk);
      reset_i = 1'b0;
      @(negedge clk);
      chk("rst_ack", 32'(ack_o), 0);
      chk("rst_txen", 32'(tx_enable_o), 0);
      chk("rst_b1", 32'(tx_byte_one_o), 0);
      chk("rst_b2", 32'(tx_byte_two_o), 0);
      chk("rst_busy", 32'(busy_o), 0);
      chk("rst_grant", 32'(grant_id_o), 0);
      chk("rst_terr", 32'(timeout_err_o), 0);
      // single frame from requester 0
      req_byte_one_i[7:0] = 8'hA5;
      req_byte_two_i[7:0] = 8'h3C;
      lq.push_back('{2'd0, 8'hA5, 8'h3C});
      aq.push_back('{4'b0001, 8'hA5, 8'h3C, 1'b0});
      req_i = 4'b0001;
      frame();
      req_i = '0;
      n = 0;
      while (busy_o && n < 50) begin @(negedge clk); n++; end
      chk("t1_gap_len", 32'(n), GAP);
      // all four held from pointer 0: 0,1,2,3,0
      reset_i = 1'b1;
      @(negedge clk);
      reset_i = 1'b0;
      for (int i = 0; i < N; i++) begin
         req_byte_one_i[8*i +: 8] = 8'h10 + 8'(i);
         req_byte_two_i[8*i +: 8] = 8'h20 + 8'(i);
      end
      for (int f = 0; f < 5; f++) begin
         lq.push_back('{2'(f % 4), 8'h10 + 8'(f % 4), 8'h20 + 8'(f % 4)});
         aq.push_back('{4'b0001 << (f % 4), 8'h10 + 8'(f % 4), 8'h20 + 8'(f % 4), 1'b0});
      end
      req_i = 4'b1111;
      for (int f = 0; f < 5; f++) frame();
      req_i = '0;
      wait_idle();
      // timeout on requester 1 with tx_done stuck low
      req_byte_one_i[15:8] = 8'h11;
      req_byte_two_i[15:8] = 8'h22;
      lq.push_back('{2'd1, 8'h11, 8'h22});
      aq.push_back('{4'b0010, 8'h11, 8'h22, 1'b1});
      req_i = 4'b0010;
      wait_en();
      n = 0;
      while (ack_o == '0 && n < 300) begin @(negedge clk); n++; end
      chk("t3_timeout_latency", 32'(n), TMO);
      chk("t3_terr_set", 32'(timeout_err_o), 1);
      req_i = '0;
      wait_idle();
      chk("t3_terr_sticky", 32'(timeout_err_o), 1);
      lq.push_back('{2'd1, 8'h11, 8'h22});
      aq.push_back('{4'b0010, 8'h11, 8'h22, 1'b0});
      req_i = 4'b0010;
      frame();
      req_i = '0;
      chk("t3_terr_clear", 32'(timeout_err_o), 0);
      wait_idle();
      // bytes latched at grant survive later input changes
      req_byte_one_i[23:16] = 8'h5A;
      req_byte_two_i[23:16] = 8'hC3;
      lq.push_back('{2'd2, 8'h5A, 8'hC3});
      aq.push_back('{4'b0100, 8'h5A, 8'hC3, 1'b0});
      req_i = 4'b0100;
      wait_en();
      req_byte_one_i[23:16] = 8'hFF;
      @(negedge clk);
      chk("t4_b1_hold", 32'(tx_byte_one_o), 32'h5A);
      drive_done();
      wait_ack();
      req_i = '0;
      wait_idle();
      // reset while waiting for the second byte
      req_byte_one_i[7:0] = 8'h66;
      req_byte_two_i[7:0] = 8'h99;
      lq.push_back('{2'd0, 8'h66, 8'h99});
      req_i = 4'b0001;
      wait_en();
      @(negedge clk);
      tx_done_i = 1'b1;
      repeat (2) @(negedge clk);
      tx_done_i = 1'b0;
      repeat (2) @(negedge clk);
      #2 reset_i = 1'b1;
      #1;
      chk("t5_rst_ack", 32'(ack_o), 0);
      chk("t5_rst_txen", 32'(tx_enable_o), 0);
      chk("t5_rst_b1", 32'(tx_byte_one_o), 0);
      chk("t5_rst_b2", 32'(tx_byte_two_o), 0);
      chk("t5_rst_busy", 32'(busy_o), 0);
      chk("t5_rst_grant", 32'(grant_id_o), 0);
      req_i = '0;
      @(negedge clk);
      reset_i = 1'b0;
      repeat (3) @(negedge clk);
      req_byte_one_i[23:16] = 8'h77;
      req_byte_two_i[23:16] = 8'h88;
      lq.push_back('{2'd2, 8'h77, 8'h88});
      aq.push_back('{4'b0100, 8'h77, 8'h88, 1'b0});
      req_i = 4'b0100;
      frame();
      req_i = '0;
      wait_idle();
      // grant 3, then 3 and 0 pending: wrap to 0
      req_byte_one_i[31:24] = 8'h31;
      req_byte_two_i[31:24] = 8'h32;
      req_byte_one_i[7:0] = 8'h01;
      req_byte_two_i[7:0] = 8'h02;
      lq.push_back('{2'd3, 8'h31, 8'h32});
      aq.push_back('{4'b1000, 8'h31, 8'h32, 1'b0});
      lq.push_back('{2'd0, 8'h01, 8'h02});
      aq.push_back('{4'b0001, 8'h01, 8'h02, 1'b0});
      req_i = 4'b1000;
      frame();
      req_i = 4'b1001;
      frame();
      req_i = '0;
      wait_idle();
      repeat (5) @(negedge clk);
      chk("launch_queue_drained", 32'(lq.size()), 0);
      chk("ack_queue_drained", 32'(aq.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
